// File: rtl/inport_ctrl.sv
// Input-port front end of the mesh router: flit FIFO, XY route of the head flit,
// wormhole request hold toward the output controllers and a registered crossbar feed.
module inport_ctrl #(
  parameter int DEPTH = 4,
  parameter int DATAW = 34,
  parameter int XW    = 2,
  parameter int YW    = 2,
  parameter int MYX   = 0,
  parameter int MYY   = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       port,
  output logic             req,
  input  logic             grt,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  output logic             err,
  output logic             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [XW-1:0] MY_X = MYX[XW-1:0];
  localparam logic [YW-1:0] MY_Y = MYY[YW-1:0];

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  state_e           state_q, state_d;
  logic [2:0]       port_q, port_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic             push, pop, empty;
  logic [DATAW-1:0] front;
  logic             front_is_head, front_is_last;
  logic [XW-1:0]    dx;
  logic [YW-1:0]    dy;
  logic [2:0]       route;

  // Handshake: a flit transfers on any clock edge where in_valid & in_ready are both 1;
  // in_ready comes only from the registered count, so a full FIFO refuses even if popping.
  assign in_ready = ~rst_ & (count_q != FULL);
  assign push     = in_valid & in_ready;
  assign empty    = (count_q == '0);

  assign front         = mem_q[rd_ptr_q];
  assign front_is_head = front[DATAW-2];   // types 01 and 11 open a packet
  assign front_is_last = front[DATAW-1];   // types 10 and 11 close a packet
  assign dx            = front[XW+YW-1:YW];
  assign dy            = front[YW-1:0];

  always_comb begin
    route = 3'd0;
    if (dx > MY_X)      route = 3'd2;
    else if (dx < MY_X) route = 3'd4;
    else if (dy > MY_Y) route = 3'd3;
    else if (dy < MY_Y) route = 3'd1;
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (front_is_head) begin
            port_d  = route;
            state_d = ACTIVE;
          end else begin
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // Request stays up across upstream bubbles so the output stays locked to this packet.
        if (grt && !empty) begin
          pop         = 1'b1;
          out_data_d  = front;
          out_valid_d = 1'b1;
          if (front_is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      port_q      <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      port_q      <= port_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign port      = port_q;
  assign req       = (state_q == ACTIVE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign dbg_state = (state_q == ACTIVE);

endmodule

// File: tb/tb_inport_ctrl.sv
// Bench for inport_ctrl: directed packet scenarios plus random traffic, checked every
// cycle against a queue-based packet model, with literal expectations at key points.
module tb_inport_ctrl;

  localparam int DEPTH = 4;
  localparam int DATAW = 34;
  localparam int MYX   = 1;
  localparam int MYY   = 1;

  logic             clk;
  logic             rst_;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       port;
  logic             req;
  logic             grt;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             err;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  inport_ctrl #(.DEPTH(DEPTH), .DATAW(DATAW), .XW(2), .YW(2), .MYX(MYX), .MYY(MYY)) dut (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .port(port), .req(req), .grt(grt), .out_data(out_data), .out_valid(out_valid),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input logic [1:0] x, input logic [1:0] y);
    logic [27:0] pl;
    pl = 28'($urandom);
    return {t, pl, x, y};
  endfunction

  function automatic logic [2:0] xy_route(input logic [DATAW-1:0] f);
    int x, y;
    x = int'(f[3:2]);
    y = int'(f[1:0]);
    if (x > MYX) return 3'd2;
    if (x < MYX) return 3'd4;
    if (y > MYY) return 3'd3;
    if (y < MYY) return 3'd1;
    return 3'd0;
  endfunction

  // ---------------- behavioural model ----------------
  logic [DATAW-1:0] exp_q[$];
  bit               m_busy = 0;
  logic [2:0]       m_port = 3'd0;
  logic [DATAW-1:0] m_out_data = '0;
  bit               m_out_valid = 0;
  bit               m_err = 0;
  int               acc_cnt = 0;
  logic [DATAW-1:0] m_f;
  logic [1:0]       m_t;
  bit               m_acc;

  always @(posedge clk) begin
    if (rst_) begin
      exp_q.delete();
      m_busy = 0; m_port = 3'd0; m_out_data = '0; m_out_valid = 0; m_err = 0;
    end else begin
      m_acc = in_valid && (exp_q.size() < DEPTH);
      m_out_valid = 0;
      m_err = 0;
      if (exp_q.size() > 0) begin
        m_f = exp_q[0];
        m_t = m_f[DATAW-1:DATAW-2];
        if (!m_busy) begin
          if (m_t == 2'b01 || m_t == 2'b11) begin
            m_busy = 1;
            m_port = xy_route(m_f);
          end else begin
            void'(exp_q.pop_front());
            m_err = 1;
          end
        end else if (grt) begin
          void'(exp_q.pop_front());
          m_out_data  = m_f;
          m_out_valid = 1;
          if (m_t == 2'b10 || m_t == 2'b11) m_busy = 0;
        end
      end
      if (m_acc) begin
        exp_q.push_back(in_data);
        acc_cnt++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("in_ready", in_ready, (!rst_ && exp_q.size() != DEPTH));
    check("req", req, m_busy);
    check("dbg_state", dbg_state, m_busy);
    check("port", port, m_port);
    check("out_valid", out_valid, m_out_valid);
    check("out_data", out_data, m_out_data);
    check("err", err, m_err);
  end

  // ---------------- driver ----------------
  logic [DATAW-1:0] stim_q[$];

  task automatic run_stim(input int vpct, input int gpct);
    int guard;
    bit hs;
    guard = 0;
    in_valid = 1'b0;
    while ((stim_q.size() > 0 || in_valid) && guard < 20000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (hs) begin
        void'(stim_q.pop_front());
        in_valid = 1'b0;
      end
      if (!in_valid && stim_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
        in_valid = 1'b1;
        in_data  = stim_q[0];
      end
      grt = ($urandom_range(0, 99) < gpct);
    end
    checks++;
    if (guard >= 20000) begin
      errors++;
      $display("FAIL stim_timeout got %0d flits left expected 0", stim_q.size());
    end
    in_valid = 1'b0;
  endtask

  logic [DATAW-1:0] f1;
  logic [DATAW-1:0] t3[6];
  int len;

  initial begin
    rst_ = 1'b1; in_valid = 1'b0; in_data = '0; grt = 1'b0;
    repeat (3) step();
    rst_ = 1'b0;

    // single-flit packet routed east, one grant
    step(); f1 = mk(2'b11, 2'd2, 2'd1); in_data = f1; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step();
    @(negedge clk);
    check("t1_port", port, 3'd2);
    check("t1_req", req, 1'b1);
    step(); grt = 1'b1;
    step(); grt = 1'b0;
    @(negedge clk);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_data", out_data, f1);
    check("t1_req_drop", req, 1'b0);

    // 4-flit packet north with grant held
    grt = 1'b1;
    step(); in_valid = 1'b1; in_data = mk(2'b01, 2'd1, 2'd0);
    step(); in_data = mk(2'b00, 2'd0, 2'd0);
    step(); in_data = mk(2'b00, 2'd0, 2'd0);
    step(); in_data = mk(2'b10, 2'd0, 2'd0);
    step(); in_valid = 1'b0;
    repeat (6) step();
    grt = 1'b0;

    // fill to full with no grant, then drain
    t3[0] = mk(2'b01, 2'd0, 2'd1); t3[1] = mk(2'b00, 2'd0, 2'd0);
    t3[2] = mk(2'b00, 2'd0, 2'd0); t3[3] = mk(2'b10, 2'd0, 2'd0);
    t3[4] = mk(2'b11, 2'd3, 2'd3); t3[5] = mk(2'b11, 2'd3, 2'd3);
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(); in_valid = 1'b1; in_data = t3[i];
      if (i == 4) begin
        @(negedge clk);
        check("t3_full_ready", in_ready, 1'b0);
      end
    end
    step(); in_valid = 1'b0;
    check("t3_accepted", acc_cnt, 4);
    grt = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("t3_ready_back", in_ready, 1'b1);
    step(); grt = 1'b0;

    // upstream stall mid-packet while granted
    step(); in_valid = 1'b1; in_data = mk(2'b01, 2'd0, 2'd0);
    step(); in_valid = 1'b0; grt = 1'b1;
    repeat (3) step();
    in_valid = 1'b1; in_data = mk(2'b00, 2'd0, 2'd0);
    step(); in_data = mk(2'b10, 2'd0, 2'd0);
    step(); in_valid = 1'b0;
    repeat (6) step();
    grt = 1'b0;

    // stray body flit while idle, then a normal packet
    step(); in_valid = 1'b1; in_data = mk(2'b00, 2'd2, 2'd2);
    step(); in_valid = 1'b0;
    step();
    @(negedge clk);
    check("t5_err", err, 1'b1);
    check("t5_req", req, 1'b0);
    @(negedge clk);
    check("t5_err_pulse", err, 1'b0);
    step(); in_valid = 1'b1; in_data = mk(2'b11, 2'd1, 2'd2);
    step(); in_valid = 1'b0; grt = 1'b1;
    repeat (4) step();
    grt = 1'b0;

    // reset between body and tail
    step(); in_valid = 1'b1; in_data = mk(2'b01, 2'd0, 2'd0);
    step(); in_data = mk(2'b00, 2'd0, 2'd0);
    step(); in_valid = 1'b0; grt = 1'b1;
    step();
    step(); rst_ = 1'b1; grt = 1'b0;
    @(negedge clk);
    check("t6_ready_in_reset", in_ready, 1'b0);
    step(); rst_ = 1'b0;
    @(negedge clk);
    check("t6_req", req, 1'b0);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_ready", in_ready, 1'b1);
    step(); in_valid = 1'b1; in_data = mk(2'b11, 2'd3, 2'd3);
    step(); in_valid = 1'b0; grt = 1'b1;
    repeat (4) step();
    grt = 1'b0;

    // random traffic: well-formed packets with occasional stray non-head flits
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 9) == 0)
        stim_q.push_back(mk(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10, 2'($urandom), 2'($urandom)));
      len = $urandom_range(1, 5);
      if (len == 1) begin
        stim_q.push_back(mk(2'b11, 2'($urandom), 2'($urandom)));
      end else begin
        stim_q.push_back(mk(2'b01, 2'($urandom), 2'($urandom)));
        for (int b = 0; b < len - 2; b++) stim_q.push_back(mk(2'b00, 2'($urandom), 2'($urandom)));
        stim_q.push_back(mk(2'b10, 2'($urandom), 2'($urandom)));
      end
    end
    run_stim(70, 60);
    grt = 1'b1;
    repeat (20) step();
    grt = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
